// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable width and parity. Received words
// land in a first-word-fall-through FIFO with per-word parity status and sticky error flags.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                               core_clk,
  input  logic                               core_rst,
  input  logic                               enable,
  input  logic [DIV_WIDTH-1:0]               clk_div,
  input  logic                               ser_rx,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [DATA_BITS-1:0]               rd_data,
  output logic                               rd_perr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               frame_err,
  output logic                               overrun,
  input  logic                               err_clr,
  output logic                               busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned SC_W  = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam int unsigned ENT_W = DATA_BITS + 1;

  localparam logic [SC_W-1:0]  SC_MID   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic             ODD_PAR  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state, state_n;
  logic [SC_W-1:0]      sc, sc_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr_q, perr_n;
  logic                 push_c, ferr_set_c;
  logic [ENT_W-1:0]     push_word_c;

  logic                 rx_meta, rx_s;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick_c;

  // Two-flop synchroniser; idles high so reset does not look like a start edge
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_s    <= rx_meta;
    end
  end

  // Oversample tick; held at zero in IDLE so the bit phase aligns to the start edge
  assign tick_c = (state != S_IDLE) && (div_cnt == clk_div);

  always_ff @(posedge core_clk) begin
    if (core_rst || state == S_IDLE) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= DIV_WIDTH'(div_cnt + 1'b1);
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state  <= S_IDLE;
      sc     <= '0;
      idx    <= '0;
      shreg  <= '0;
      perr_q <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      sc     <= sc_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      perr_q <= perr_n;
      busy   <= (state_n != S_IDLE);
    end
  end

  always_comb begin
    state_n     = state;
    sc_n        = sc;
    idx_n       = idx;
    shreg_n     = shreg;
    perr_n      = perr_q;
    push_c      = 1'b0;
    ferr_set_c  = 1'b0;
    push_word_c = {perr_q, shreg};
    if (!enable) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_n = S_START;
            sc_n    = '0;
          end
        end
        S_START: begin
          if (tick_c) begin
            if (sc == SC_MID) begin
              sc_n  = '0;
              idx_n = '0;
              state_n = rx_s ? S_IDLE : S_DATA;
            end else begin
              sc_n = sc + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick_c) begin
            if (sc == SC_LAST) begin
              sc_n    = '0;
              shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
              idx_n   = idx + 1'b1;
              if (idx == IDX_LAST) begin
                perr_n  = 1'b0;
                state_n = (PARITY != 0) ? S_PARITY : S_STOP;
              end
            end else begin
              sc_n = sc + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick_c) begin
            if (sc == SC_LAST) begin
              sc_n    = '0;
              perr_n  = ((^shreg) ^ rx_s) != ODD_PAR;
              state_n = S_STOP;
            end else begin
              sc_n = sc + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick_c) begin
            if (sc == SC_LAST) begin
              sc_n = '0;
              if (rx_s) begin
                push_c  = 1'b1;
                state_n = S_IDLE;
              end else begin
                ferr_set_c = 1'b1;
                state_n    = S_BREAK;
              end
            end else begin
              sc_n = sc + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic             full_c, pop_c, wr_en_c, drop_c;
  logic [CNT_W-1:0] count_n;
  logic [ENT_W-1:0] head_n;

  assign full_c     = (fifo_count == CNT_FULL);
  assign pop_c      = rd_valid && rd_ready;
  assign wr_en_c    = push_c && (!full_c || pop_c);
  assign drop_c     = push_c && full_c && !pop_c;
  assign rd_ptr_inc = PTR_W'(rd_ptr + 1'b1);

  // Next head: rd_data is a register holding the word that will be at the head
  always_comb begin
    count_n = fifo_count;
    case ({wr_en_c, pop_c})
      2'b10:   count_n = fifo_count + CNT_W'(1);
      2'b01:   count_n = fifo_count - CNT_W'(1);
      default: count_n = fifo_count;
    endcase
    head_n = {rd_perr, rd_data};
    if (pop_c) begin
      if (fifo_count > CNT_W'(1)) begin
        head_n = mem[rd_ptr_inc];
      end else if (wr_en_c) begin
        head_n = push_word_c;
      end else begin
        head_n = '0;
      end
    end else if (fifo_count == '0 && wr_en_c) begin
      head_n = push_word_c;
    end
  end

  always_ff @(posedge core_clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= push_word_c;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_perr    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr_inc;
      end
      fifo_count         <= count_n;
      rd_valid           <= (count_n != '0);
      {rd_perr, rd_data} <= head_n;
      // A new error in the same cycle as err_clr wins
      frame_err          <= ferr_set_c | (frame_err & ~err_clr);
      overrun            <= drop_c | (overrun & ~err_clr);
    end
  end

endmodule
